// File: rtl/dmem_bus_if.sv
// dmem_bus_if: data-memory stage that turns datapath loads/stores into req/ack word-bus transactions.
// Holds the datapath with stall until the access retires and flags misaligned, erroring or timed-out accesses.
module dmem_bus_if #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memread,
    input  logic          memwrite,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] writedata,
    output logic [DW-1:0] readdata,
    output logic          stall,
    output logic          err,
    input  logic          err_clr,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ack,
    input  logic          bus_err,
    input  logic [DW-1:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    localparam logic [7:0] LP_TMAX = 8'(TIMEOUT - 1);
    state_t        r_state, w_next;
    logic [7:0]    r_cnt;
    logic          r_req, r_we, r_err;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata, r_readdata;
    logic          w_access, w_misalign, w_start, w_misload, w_timeout, w_finish, w_ok, w_err_set;
    assign w_access   = memread | memwrite;
    assign w_misalign = addr[1:0] != 2'b00;
    assign w_start    = (r_state == IDLE) & w_access & ~w_misalign;
    assign w_misload  = (r_state == IDLE) & w_access & w_misalign & ~memwrite;
    assign w_timeout  = r_cnt == LP_TMAX;
    // an ack in the timeout cycle still completes normally
    assign w_finish   = (r_state == REQ) & (bus_ack | w_timeout);
    assign w_ok       = bus_ack & ~bus_err;
    assign w_err_set  = ((r_state == IDLE) & w_access & w_misalign) | (w_finish & ~w_ok);
    assign stall      = ((r_state == IDLE) & w_access) | (r_state == REQ);
    assign readdata   = r_readdata;
    assign err        = r_err;
    assign bus_req    = r_req;
    assign bus_we     = r_we;
    assign bus_addr   = r_addr;
    assign bus_wdata  = r_wdata;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_access ? (w_misalign ? DONE : REQ) : IDLE;
            REQ:     w_next = w_finish ? DONE : REQ;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_readdata <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_start) begin
                r_req   <= 1'b1;
                r_we    <= memwrite;
                r_addr  <= {addr[AW-1:2], 2'b00};
                r_wdata <= writedata;
                r_cnt   <= '0;
            end
            if (r_state == REQ) begin
                r_cnt <= r_cnt + 8'd1;
                if (w_finish) begin
                    r_req <= 1'b0;
                    if (!r_we) r_readdata <= w_ok ? bus_rdata : '0;
                end
            end
            if (w_misload) r_readdata <= '0;
            r_err <= w_err_set | (r_err & ~err_clr);
        end
    end
endmodule

// File: tb/tb_dmem_bus_if.sv
// tb_dmem_bus_if: directed scenario tests for dmem_bus_if with a short timeout.
module tb_dmem_bus_if;
    logic        clk = 1'b0, reset = 1'b0;
    logic        memread = 1'b0, memwrite = 1'b0, err_clr = 1'b0;
    logic [31:0] addr = '0, writedata = '0, bus_rdata = '0;
    logic        bus_ack = 1'b0, bus_err = 1'b0;
    logic [31:0] readdata, bus_addr, bus_wdata;
    logic        stall, err, bus_req, bus_we;
    int          total = 0, bad = 0, rises = 0;

    dmem_bus_if #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite), .addr(addr),
        .writedata(writedata), .readdata(readdata), .stall(stall), .err(err), .err_clr(err_clr),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge bus_req) rises++;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", bus_req); end
        total++; if (readdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", readdata); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_load();
        cyc(); memread = 1'b1; addr = 32'h10;
        @(negedge clk);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL ld_stall0 got=%b exp=1", stall); end
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL ld_req0 got=%b exp=0", bus_req); end
        cyc(); bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL ld_stall1 got=%b exp=1", stall); end
        total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL ld_req1 got=%b exp=1", bus_req); end
        total++; if (bus_addr !== 32'h10) begin bad++; $display("FAIL ld_addr got=%h exp=10", bus_addr); end
        total++; if (bus_we !== 1'b0) begin bad++; $display("FAIL ld_we got=%b exp=0", bus_we); end
        cyc(); bus_ack = 1'b0; memread = 1'b0;
        @(negedge clk);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL ld_done_stall got=%b exp=0", stall); end
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL ld_done_req got=%b exp=0", bus_req); end
        total++; if (readdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL ld_rdata got=%h exp=cafef00d", readdata); end
    endtask

    task automatic test_store();
        cyc(); memwrite = 1'b1; addr = 32'h20; writedata = 32'h1234_5678;
        @(negedge clk);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL st_stall0 got=%b exp=1", stall); end
        for (int i = 0; i < 3; i++) begin
            cyc(); memwrite = 1'b0; writedata = 32'hFFFF_0000; addr = 32'h99; bus_ack = (i == 2);
            @(negedge clk);
            total++; if (stall !== 1'b1) begin bad++; $display("FAIL st_stall%0d got=%b exp=1", i, stall); end
            total++; if (bus_req !== 1'b1 || bus_we !== 1'b1) begin bad++; $display("FAIL st_req%0d got=%b/%b exp=1/1", i, bus_req, bus_we); end
            total++; if (bus_wdata !== 32'h1234_5678) begin bad++; $display("FAIL st_wdata%0d got=%h exp=12345678", i, bus_wdata); end
            total++; if (bus_addr !== 32'h20) begin bad++; $display("FAIL st_addr%0d got=%h exp=20", i, bus_addr); end
        end
        cyc(); bus_ack = 1'b0;
        @(negedge clk);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL st_done_stall got=%b exp=0", stall); end
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL st_done_req got=%b exp=0", bus_req); end
        total++; if (readdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL st_rdata got=%h exp=cafef00d", readdata); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL st_err got=%b exp=0", err); end
    endtask

    task automatic test_misalign();
        int r0;
        r0 = rises;
        cyc(); memread = 1'b1; addr = 32'h13;
        @(negedge clk);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL mis_stall0 got=%b exp=1", stall); end
        cyc(); memread = 1'b0;
        @(negedge clk);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL mis_stall1 got=%b exp=0", stall); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL mis_err got=%b exp=1", err); end
        total++; if (readdata !== 32'h0) begin bad++; $display("FAIL mis_rdata got=%h exp=0", readdata); end
        total++; if (rises != r0) begin bad++; $display("FAIL mis_noreq got=%0d exp=%0d", rises, r0); end
        cyc(); err_clr = 1'b1;
        cyc(); err_clr = 1'b0;
        @(negedge clk);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL mis_errclr got=%b exp=0", err); end
    endtask

    task automatic test_timeout(input bit ack4);
        cyc(); memread = 1'b1; addr = 32'h40; bus_rdata = 32'hA5A5_5A5A;
        @(negedge clk);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL to%0d_stall0 got=%b exp=1", ack4, stall); end
        for (int i = 0; i < 4; i++) begin
            cyc(); memread = 1'b0; bus_ack = ack4 && (i == 3);
            @(negedge clk);
            total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL to%0d_req%0d got=%b exp=1", ack4, i, bus_req); end
        end
        cyc(); bus_ack = 1'b0;
        @(negedge clk);
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL to%0d_drop got=%b exp=0", ack4, bus_req); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL to%0d_done got=%b exp=0", ack4, stall); end
        total++; if (err !== !ack4) begin bad++; $display("FAIL to%0d_err got=%b exp=%b", ack4, err, !ack4); end
        total++; if (readdata !== (ack4 ? 32'hA5A5_5A5A : 32'h0)) begin bad++; $display("FAIL to%0d_rdata got=%h", ack4, readdata); end
        cyc(); err_clr = 1'b1;
        cyc(); err_clr = 1'b0;
    endtask

    task automatic test_bus_err();
        cyc(); memread = 1'b1; addr = 32'h44;
        cyc(); memread = 1'b0; bus_ack = 1'b1; bus_err = 1'b1; err_clr = 1'b1; bus_rdata = 32'h1111_2222;
        @(negedge clk);
        total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL be_req got=%b exp=1", bus_req); end
        cyc(); bus_ack = 1'b0; bus_err = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL be_setwins got=%b exp=1", err); end
        total++; if (readdata !== 32'h0) begin bad++; $display("FAIL be_rdata got=%h exp=0", readdata); end
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL be_drop got=%b exp=0", bus_req); end
    endtask

    task automatic test_reset_mid();
        cyc(); memread = 1'b1; addr = 32'h50;
        cyc(); memread = 1'b0;
        @(negedge clk);
        total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL rm_req got=%b exp=1", bus_req); end
        cyc(); #1 reset = 1'b0;
        #1;
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL rm_async_req got=%b exp=0", bus_req); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rm_stall got=%b exp=0", stall); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rm_err got=%b exp=0", err); end
        @(negedge clk) reset = 1'b1;
        cyc(); bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        total++; if (bus_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL rm_idle got=%b/%b exp=0/0", bus_req, stall); end
        cyc(); bus_ack = 1'b0;
        @(negedge clk);
        total++; if (readdata !== 32'h0) begin bad++; $display("FAIL rm_lateack got=%h exp=0", readdata); end
    endtask

    task automatic test_back_to_back();
        int r0;
        r0 = rises;
        cyc(); memwrite = 1'b1; addr = 32'h30; writedata = 32'hDEAD_BEEF;
        cyc(); bus_ack = 1'b1;
        @(negedge clk);
        total++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h30) begin bad++; $display("FAIL bb_st got=%b/%b/%h exp=1/1/30", bus_req, bus_we, bus_addr); end
        cyc(); bus_ack = 1'b0; memwrite = 1'b0;
        @(negedge clk);
        total++; if (bus_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL bb_done1 got=%b/%b exp=0/0", bus_req, stall); end
        cyc(); memread = 1'b1; addr = 32'h34;
        @(negedge clk);
        total++; if (bus_req !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL bb_idle got=%b/%b exp=0/1", bus_req, stall); end
        cyc(); bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        total++; if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 32'h34) begin bad++; $display("FAIL bb_ld got=%b/%b/%h exp=1/0/34", bus_req, bus_we, bus_addr); end
        cyc(); bus_ack = 1'b0; memread = 1'b0;
        @(negedge clk);
        total++; if (readdata !== 32'h0BAD_F00D) begin bad++; $display("FAIL bb_rdata got=%h exp=0badf00d", readdata); end
        total++; if (rises - r0 != 2) begin bad++; $display("FAIL bb_reqcount got=%0d exp=2", rises - r0); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_misalign();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_bus_err();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
